// File: rtl/gpio_cmd_conditioner.sv
`timescale 1ns/1ps
// ============================================================================
// gpio_cmd_conditioner
//
// Purpose
//   Turns raw asynchronous GPIO pins into clean per-channel commands. Each
//   channel goes through three steps:
//     1. A SYNC_STAGES-deep synchronizer chain. The last flop gives the synced
//        level.
//     2. A debouncer. A new synced level is accepted only after it has stayed
//        different from the current debounced level for DEBOUNCE_CYCLES
//        consecutive enabled cycles. Any shorter glitch restarts the count.
//     3. An edge qualifier. It sends a one-cycle gpio_cmd pulse when the
//        debounced level changes in a direction enabled by edge_mode. It also
//        sets a sticky cmd_pending flag that software clears with cmd_clr.
//
//   A pin that changes before edge 0 and then holds updates gpio_level on
//   edge SYNC_STAGES + DEBOUNCE_CYCLES - 1.
//
// Parameters
//   NUM_CH          number of independent channels, 1..16
//   SYNC_STAGES     synchronizer depth, >= 2
//   DEBOUNCE_CYCLES stable synced cycles needed to accept a level, 1..255
//
// Ports
//   clk          in   single clock, rising-edge
//   rstb         in   asynchronous active-low reset
//   ena          in   block enable. When low, all state holds, gpio_cmd
//                     reads 0 and cmd_clr is ignored.
//   gpio_in      in   [NUM_CH]     raw pins
//   edge_mode    in   [2*NUM_CH]   bits [2i+1:2i] for channel i:
//                                  00 none, 01 rising, 10 falling, 11 both
//   cmd_clr      in   [NUM_CH]     clears cmd_pending[i]. A set on the same
//                                  edge wins over the clear.
//   gpio_level   out  [NUM_CH]     debounced level
//   gpio_cmd     out  [NUM_CH]     registered one-cycle command pulse
//   cmd_pending  out  [NUM_CH]     sticky command flag
// ============================================================================
module gpio_cmd_conditioner #(
    parameter int NUM_CH          = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ena,
    input  logic [NUM_CH-1:0]     gpio_in,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    input  logic [NUM_CH-1:0]     cmd_clr,
    output logic [NUM_CH-1:0]     gpio_level,
    output logic [NUM_CH-1:0]     gpio_cmd,
    output logic [NUM_CH-1:0]     cmd_pending
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("gpio_cmd_conditioner: NUM_CH=%0d outside 1..16", NUM_CH);
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("gpio_cmd_conditioner: SYNC_STAGES=%0d below 2", SYNC_STAGES);
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("gpio_cmd_conditioner: DEBOUNCE_CYCLES=%0d outside 1..255",
               DEBOUNCE_CYCLES);
    end

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // The count at which the next differing cycle would reach DEBOUNCE_CYCLES.
    // At that point the level is accepted instead of incrementing again.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Per-channel datapath. Channels share nothing but clk, rstb and ena.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   cmd_q;
        logic                   pend_q;

        logic                   synced;
        logic [1:0]             mode;
        logic                   accept;
        logic                   cmd_d;

        assign synced = sync_q[SYNC_STAGES-1];
        assign mode   = edge_mode[2*i +: 2];

        // The debounced level flips on this edge.
        assign accept = (synced != level_q) && (cnt_q == CNT_LAST);

        // Direction is judged from the value being accepted.
        // mode[0] enables rising edges and mode[1] enables falling edges.
        // edge_mode is only looked at while accept is high, so changing the
        // mode at any other time cannot create a command.
        assign cmd_d = accept && (synced ? mode[0] : mode[1]);

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values. The synchronizer chain relies on this
        // to shift by exactly one stage per edge.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                // NOTE: the synchronizer flops are reset too, so the block
                // always restarts from a known all-zero state. A pin that is
                // high at release then appears as an ordinary rising edge.
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                cmd_q   <= 1'b0;
                pend_q  <= 1'b0;
            end else if (ena) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in[i]};

                if (synced == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_q <= synced;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end

                cmd_q  <= cmd_d;
                // A set on the same edge as a clear wins.
                pend_q <= cmd_d | (pend_q & ~cmd_clr[i]);
            end else begin
                // While disabled, only the pulse output is forced low.
                // Everything else holds, and nothing is replayed on resume.
                cmd_q <= 1'b0;
            end
        end

        assign gpio_level[i]  = level_q;
        assign gpio_cmd[i]    = cmd_q;
        assign cmd_pending[i] = pend_q;
    end

endmodule

// File: tb/tb_gpio_cmd_conditioner.sv
`timescale 1ns/1ps
// ============================================================================
// tb_gpio_cmd_conditioner
//
// Self-checking bench for gpio_cmd_conditioner with default parameters.
//
// The reference model describes behaviour, not flops:
//   - the synced level is the pin value seen SYNC_STAGES enabled edges ago,
//     held in a FIFO queue;
//   - a new debounced level is accepted when the last DEBOUNCE_CYCLES synced
//     samples all differ from the current level, tracked as a sliding window.
//
// Directed scenarios run first, followed by a randomized phase. All three
// outputs are compared with the model after every clock edge.
// ============================================================================
module tb_gpio_cmd_conditioner;

    localparam int NUM_CH          = 2;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    logic                clk       = 1'b0;
    logic                rstb      = 1'b0;
    logic                ena       = 1'b0;
    logic [NUM_CH-1:0]   gpio_in   = '0;
    logic [2*NUM_CH-1:0] edge_mode = '0;
    logic [NUM_CH-1:0]   cmd_clr   = '0;
    logic [NUM_CH-1:0]   gpio_level;
    logic [NUM_CH-1:0]   gpio_cmd;
    logic [NUM_CH-1:0]   cmd_pending;

    gpio_cmd_conditioner #(
        .NUM_CH          (NUM_CH),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .gpio_in     (gpio_in),
        .edge_mode   (edge_mode),
        .cmd_clr     (cmd_clr),
        .gpio_level  (gpio_level),
        .gpio_cmd    (gpio_cmd),
        .cmd_pending (cmd_pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses0 = 0;   // observed gpio_cmd[0] pulses since the last zeroing

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    bit                m_pin_q [NUM_CH][$];  // pin samples still in flight
    bit                m_win   [NUM_CH][$];  // last DEBOUNCE_CYCLES synced samples
    logic [NUM_CH-1:0] m_level;
    logic [NUM_CH-1:0] m_cmd;
    logic [NUM_CH-1:0] m_pend;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pin_q[i] = {};
            for (int k = 0; k < SYNC_STAGES; k++) m_pin_q[i].push_back(1'b0);
            m_win[i] = {};
        end
        m_level = '0;
        m_cmd   = '0;
        m_pend  = '0;
    endtask

    // Predict the state after the coming rising edge from the current inputs.
    task automatic model_edge();
        bit       s;
        bit       upd;
        bit [1:0] mode;
        bit       c;
        if (!rstb) begin
            model_reset();
            return;
        end
        if (!ena) begin
            m_cmd = '0;
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            s = m_pin_q[i].pop_front();
            m_pin_q[i].push_back(gpio_in[i]);
            m_win[i].push_back(s);
            if (m_win[i].size() > DEBOUNCE_CYCLES) void'(m_win[i].pop_front());
            upd = (m_win[i].size() == DEBOUNCE_CYCLES);
            for (int k = 0; k < m_win[i].size(); k++)
                if (m_win[i][k] == m_level[i]) upd = 1'b0;
            mode = edge_mode[2*i +: 2];
            c = upd && (s ? mode[0] : mode[1]);
            if (upd) m_level[i] = s;
            m_cmd[i]  = c;
            m_pend[i] = c | (m_pend[i] & ~cmd_clr[i]);
        end
    endtask

    // Advance one clock. Inputs must already be set. Outputs are compared
    // with the model 1 ns after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("level",   32'(gpio_level),  32'(m_level));
        check("cmd",     32'(gpio_cmd),    32'(m_cmd));
        check("pending", 32'(cmd_pending), 32'(m_pend));
        if (gpio_cmd[0]) pulses0++;
    endtask

    initial begin
        model_reset();

        // ---------------- reset state ----------------
        #1;
        check("rst_level",   32'(gpio_level),  32'd0);
        check("rst_cmd",     32'(gpio_cmd),    32'd0);
        check("rst_pending", 32'(cmd_pending), 32'd0);
        tick();
        tick();
        rstb      = 1'b1;
        ena       = 1'b1;
        edge_mode = 4'b0101;            // both channels: rising only
        repeat (3) tick();

        // ---------------- single rising command on ch0 ----------------
        gpio_in[0] = 1'b1;              // set up before edge 0
        repeat (5) tick();              // edges 0..4
        check("rise_lvl_pre_e5", 32'(gpio_level[0]), 32'd0);
        check("rise_cmd_pre_e5", 32'(gpio_cmd[0]),   32'd0);
        tick();                         // edge 5
        check("rise_lvl_e5", 32'(gpio_level[0]), 32'd1);
        check("rise_cmd_e5", 32'(gpio_cmd[0]),   32'd1);
        tick();
        check("rise_cmd_e6",  32'(gpio_cmd[0]),    32'd0);
        check("rise_pend_e6", 32'(cmd_pending[0]), 32'd1);
        repeat (3) tick();
        check("rise_pend_hold", 32'(cmd_pending[0]), 32'd1);
        cmd_clr[0] = 1'b1;
        tick();
        cmd_clr[0] = 1'b0;
        check("rise_pend_clr", 32'(cmd_pending[0]), 32'd0);

        // ---------------- short glitch is rejected ----------------
        gpio_in[0] = 1'b0;              // falling edge, mode 01 gives no cmd
        repeat (8) tick();
        check("fall_no_cmd_lvl", 32'(gpio_level[0]), 32'd0);
        pulses0 = 0;
        gpio_in[0] = 1'b1;
        repeat (2) tick();
        gpio_in[0] = 1'b0;
        repeat (10) tick();
        check("glitch_lvl",    32'(gpio_level[0]), 32'd0);
        check("glitch_pulses", 32'(pulses0),       32'd0);

        // ---------------- mode 11 then mode 10 ----------------
        edge_mode[1:0] = 2'b11;
        pulses0 = 0;
        gpio_in[0] = 1'b1;
        repeat (10) tick();
        gpio_in[0] = 1'b0;
        repeat (10) tick();
        check("both_pulses", 32'(pulses0), 32'd2);
        edge_mode[1:0] = 2'b10;
        pulses0 = 0;
        gpio_in[0] = 1'b1;
        repeat (10) tick();
        check("fall_mode_no_rise", 32'(pulses0), 32'd0);
        gpio_in[0] = 1'b0;
        repeat (10) tick();
        check("fall_mode_pulses", 32'(pulses0), 32'd1);

        // ---------------- set wins over a simultaneous clear on ch1 ----------------
        gpio_in[1] = 1'b1;
        repeat (5) tick();
        cmd_clr[1] = 1'b1;
        tick();                         // edge 5: command and clear together
        check("setclr_cmd",  32'(gpio_cmd[1]),    32'd1);
        check("setclr_pend", 32'(cmd_pending[1]), 32'd1);
        tick();
        cmd_clr[1] = 1'b0;
        check("clr_next_pend", 32'(cmd_pending[1]), 32'd0);

        // ---------------- enable gap during a pin edge ----------------
        edge_mode[1:0] = 2'b01;
        gpio_in[0] = 1'b1;
        repeat (3) tick();              // synced at edge 1, count=1 after edge 2
        ena = 1'b0;
        cmd_clr = '1;                   // must be ignored while disabled
        pulses0 = 0;
        repeat (20) tick();
        check("dis_pulses", 32'(pulses0),       32'd0);
        check("dis_lvl",    32'(gpio_level[0]), 32'd0);
        cmd_clr = '0;
        ena = 1'b1;
        repeat (2) tick();
        check("resume_no_cmd_yet", 32'(gpio_cmd[0]), 32'd0);
        tick();
        check("resume_cmd", 32'(gpio_cmd[0]), 32'd1);

        // ---------------- reset mid-debounce ----------------
        gpio_in[0] = 1'b0;
        repeat (8) tick();
        gpio_in[0] = 1'b1;
        repeat (4) tick();              // counter now 2 for the pending rise
        check("pre_rst_pend", 32'(cmd_pending[0]), 32'd1);
        #2 rstb = 1'b0;
        #1;
        model_reset();
        check("mid_rst_level",   32'(gpio_level),  32'd0);
        check("mid_rst_cmd",     32'(gpio_cmd),    32'd0);
        check("mid_rst_pending", 32'(cmd_pending), 32'd0);
        tick();
        tick();
        rstb = 1'b1;                    // released before edge 0, pin still high
        repeat (5) tick();
        check("post_rst_no_cmd", 32'(gpio_cmd[0]), 32'd0);
        tick();
        check("post_rst_cmd_e5", 32'(gpio_cmd[0]), 32'd1);

        // ---------------- randomized phase ----------------
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(5) == 0) gpio_in[i] = ~gpio_in[i];
            if ($urandom_range(19) == 0) edge_mode = 4'($urandom);
            cmd_clr = ($urandom_range(7) == 0) ? NUM_CH'($urandom) : '0;
            ena     = ($urandom_range(9) != 0);
            tick();
        end
        ena     = 1'b1;
        cmd_clr = '0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_cmd_conditioner.md
GPIO_CMD_CONDITIONER -- requirements
Module: gpio_cmd_conditioner

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent GPIO channels, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, legal minimum 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synced cycles needed to accept a new level, legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstb  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  block enable.
REQ-007 gpio_in  input  NUM_CH  raw asynchronous GPIO pins.
REQ-008 edge_mode  input  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
REQ-009 cmd_clr  input  NUM_CH  per-channel clear of the sticky pending flag.
REQ-010 gpio_level  output  NUM_CH  debounced level per channel.
REQ-011 gpio_cmd  output  NUM_CH  one-cycle command pulse per qualifying debounced edge.
REQ-012 cmd_pending  output  NUM_CH  sticky flag set by a command, held until cleared.

Function
REQ-013 Each channel SHALL pass gpio_in[i] through a SYNC_STAGES-deep flop chain; the last stage is the synced level.
REQ-014 Each channel SHALL hold a debounce counter of width $clog2(DEBOUNCE_CYCLES+1) and a debounced level register.
REQ-015 While synced level equals the debounced level, the counter SHALL be 0 on the next edge.
REQ-016 While synced level differs, the counter SHALL increment each cycle; in the cycle it would reach DEBOUNCE_CYCLES, the debounced level SHALL take the synced value and the counter SHALL return to 0.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL restart the count and SHALL NOT change gpio_level.
REQ-018 Latency: a pin change set up before edge 0 and held SHALL update gpio_level on edge SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: edge 5).
REQ-019 gpio_cmd[i] SHALL be registered and assert for exactly one cycle on the same edge gpio_level[i] changes, when that direction matches edge_mode[i] (0->1 rising, 1->0 falling, either for 11); mode 00 never asserts.
REQ-020 edge_mode SHALL be sampled at the level-update edge; mode changes never generate commands by themselves.
REQ-021 cmd_pending[i] SHALL set on the edge gpio_cmd[i] asserts and clear on an edge with cmd_clr[i]=1; simultaneous set and clear SHALL leave it set.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulse in the same cycle.
REQ-023 With ena=0, synchronizers, counters, gpio_level and cmd_pending SHALL hold; gpio_cmd SHALL be 0 from the next edge; cmd_clr SHALL be ignored.
REQ-024 On ena returning to 1, processing SHALL resume from the held state with no replayed pulses.
REQ-025 Illegal parameter values SHALL be rejected at elaboration.

Reset
REQ-026 rstb=0 SHALL immediately force all synchronizer flops, counters, gpio_level, gpio_cmd and cmd_pending to 0, including mid-debounce.
REQ-027 A pin already high at reset release SHALL be treated as a rising edge after the REQ-018 latency.
REQ-028 Reset release SHALL be synchronous-safe; the first state update occurs on the first rising clk edge with rstb=1.

Verification
REQ-029 Defaults, mode 01, ch0 0->1 held -> gpio_level[0]=1 and a single 1-cycle gpio_cmd[0] on edge 5; cmd_pending[0]=1 until cmd_clr[0] pulse.
REQ-030 ch0 high for 2 clk cycles then low, DEBOUNCE_CYCLES=4 -> gpio_level and gpio_cmd stay 0.
REQ-031 Mode 11, 0->1 then 1->0 after 10 cycles -> two pulses; mode 10 with the same stimulus -> only the falling pulse.
REQ-032 cmd_clr[1]=1 on the same edge as gpio_cmd[1] -> cmd_pending[1]=1 afterwards; clear one cycle later -> 0.
REQ-033 ena=0 for 20 cycles during a pin edge -> no pulse, state held; ena=1 -> pulse after the remaining debounce cycles only.
REQ-034 rstb asserted mid-count (counter=2) -> all outputs 0 at once; pin high at release -> rising pulse on edge 5.
